elevator_call_scheduler: RTL and testbench



---
 rtl/elevator_pkg.sv | 9 +
 rtl/elevator_next_target.sv | 38 +++
 rtl/elevator_call_scheduler.sv | 113 +++++++++++
 tb/tb_elevator_call_scheduler.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state encoding, drive direction codes and floor-width helper
package elevator_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, MOVING, DOOR} state_t;
   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;
   function automatic int floor_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/elevator_next_target.sv
// elevator_next_target: SCAN pick of the nearest pending floor, reversing the sweep when needed
module elevator_next_target
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = 3,
   parameter int FLOOR_W    = floor_w(NUM_FLOORS)
) (
   input  logic [NUM_FLOORS-1:0] pending,
   input  logic [FLOOR_W-1:0]    current_floor,
   input  logic                  dir,
   output logic                  found,
   output logic [FLOOR_W-1:0]    target,
   output logic                  new_dir
);
   logic               up_found, dn_found;
   logic [FLOOR_W-1:0] up_t, dn_t;
   always_comb begin
      up_found = 1'b0;
      dn_found = 1'b0;
      up_t     = '0;
      dn_t     = '0;
      // descending scan leaves the lowest floor above, ascending scan the highest below
      for (int i = NUM_FLOORS - 1; i >= 0; i--)
         if (pending[i] && FLOOR_W'(i) > current_floor) begin
            up_found = 1'b1;
            up_t     = FLOOR_W'(i);
         end
      for (int i = 0; i < NUM_FLOORS; i++)
         if (pending[i] && FLOOR_W'(i) < current_floor) begin
            dn_found = 1'b1;
            dn_t     = FLOOR_W'(i);
         end
      found   = up_found | dn_found;
      new_dir = (dir == DIR_UP) ? (up_found ? DIR_UP : (dn_found ? DIR_DOWN : dir))
                                : (dn_found ? DIR_DOWN : (up_found ? DIR_UP : dir));
      target  = (new_dir == DIR_UP) ? up_t : dn_t;
   end
endmodule

// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler: latches floor calls, issues SCAN move commands, holds door dwell
module elevator_call_scheduler
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS  = 3,
   parameter int FLOOR_W     = floor_w(NUM_FLOORS),
   parameter int DOOR_CYCLES = 100000000
) (
   input  logic                  clk,
   input  logic                  reset_p,
   input  logic [NUM_FLOORS-1:0] call_pe,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic                  cmd_dir,
   output logic [FLOOR_W-1:0]    cmd_dist,
   input  logic                  move_done,
   output logic [FLOOR_W-1:0]    current_floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  door_open,
   output logic                  busy
);
   localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   state_t                state_q, state_d;
   logic [FLOOR_W-1:0]    target_q, target_d, dist_q, dist_d, cur_q, cur_d;
   logic                  dir_q, dir_d, sweep_q, sweep_d;
   logic [NUM_FLOORS-1:0] pending_q, pending_d, own_mask;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  own_call, take, nt_found, nt_dir;
   logic [FLOOR_W-1:0]    nt_target;
   elevator_next_target #(
      .NUM_FLOORS(NUM_FLOORS),
      .FLOOR_W   (FLOOR_W)
   ) u_next (
      .pending      (pending_q),
      .current_floor(cur_q),
      .dir          (sweep_q),
      .found        (nt_found),
      .target       (nt_target),
      .new_dir      (nt_dir)
   );
   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      dir_d     = dir_q;
      dist_d    = dist_q;
      cur_d     = cur_q;
      sweep_d   = sweep_q;
      cnt_d     = cnt_q;
      take      = 1'b0;
      // a call for the floor the car stands at serves the door instead of latching
      own_mask  = (state_q == IDLE || state_q == DOOR) ? (NUM_FLOORS'(1) << cur_q) : '0;
      own_call  = |(call_pe & own_mask);
      pending_d = pending_q | (call_pe & ~own_mask);
      case (state_q)
         IDLE:
            if (own_call) begin
               state_d = DOOR;
               cnt_d   = '0;
            end else if (nt_found) take = 1'b1;
         ISSUE:
            if (cmd_ready) state_d = MOVING;
         MOVING:
            if (move_done) begin
               cur_d              = target_q;
               pending_d[target_q] = 1'b0;
               state_d            = DOOR;
               cnt_d              = '0;
            end
         DOOR:
            if (own_call) cnt_d = '0;
            else if (cnt_q == CNT_W'(DOOR_CYCLES - 1)) begin
               cnt_d = '0;
               if (nt_found) take = 1'b1;
               else state_d = IDLE;
            end else cnt_d = cnt_q + 1'b1;
         default: state_d = IDLE;
      endcase
      if (take) begin
         state_d  = ISSUE;
         target_d = nt_target;
         dir_d    = nt_dir;
         sweep_d  = nt_dir;
         dist_d   = (nt_target > cur_q) ? nt_target - cur_q : cur_q - nt_target;
      end
   end
   always_ff @(posedge clk or posedge reset_p)
      if (reset_p) begin
         state_q   <= IDLE;
         target_q  <= '0;
         dir_q     <= DIR_UP;
         dist_q    <= '0;
         cur_q     <= '0;
         sweep_q   <= DIR_UP;
         pending_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         target_q  <= target_d;
         dir_q     <= dir_d;
         dist_q    <= dist_d;
         cur_q     <= cur_d;
         sweep_q   <= sweep_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
      end
   assign cmd_valid     = (state_q == ISSUE);
   assign cmd_dir       = dir_q;
   assign cmd_dist      = dist_q;
   assign current_floor = cur_q;
   assign pending       = pending_q;
   assign door_open     = (state_q == DOOR);
   assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// tb_elevator_call_scheduler: scoreboard bench for the SCAN call scheduler
module tb_elevator_call_scheduler;
   logic       clk = 1'b0;
   logic       reset_p = 1'b1;
   logic [2:0] call_pe = '0;
   logic       cmd_valid, cmd_ready = 1'b1, cmd_dir, move_done = 1'b0, door_open, busy;
   logic [1:0] cmd_dist, current_floor;
   logic [2:0] pending;
   logic [2:0] exp_q[$];
   int         n_tests = 0, n_fail = 0;
   always #5 clk = ~clk;
   elevator_call_scheduler #(
      .NUM_FLOORS (3),
      .FLOOR_W    (2),
      .DOOR_CYCLES(10)
   ) dut (
      .clk          (clk),
      .reset_p      (reset_p),
      .call_pe      (call_pe),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_dir      (cmd_dir),
      .cmd_dist     (cmd_dist),
      .move_done    (move_done),
      .current_floor(current_floor),
      .pending      (pending),
      .door_open    (door_open),
      .busy         (busy)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   always @(negedge clk)
      if (cmd_valid && cmd_ready) begin
         if (exp_q.size() == 0) chk("cmd_unexpected", exp_q.size(), 1);
         else chk("cmd_payload", {29'd0, cmd_dir, cmd_dist}, {29'd0, exp_q.pop_front()});
      end
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      reset_p = 1'b1;
      cyc(2);
      reset_p = 1'b0;
      cyc(1);
   endtask
   task automatic pulse_call(input logic [2:0] c);
      call_pe = c;
      cyc(1);
      call_pe = '0;
   endtask
   task automatic wait_accept();
      bit ok = 0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         ok = cmd_valid && cmd_ready;
      end
      chk("accept_seen", ok, 1);
      cyc(1);
   endtask
   task automatic do_move(input int dly);
      cyc(dly);
      move_done = 1'b1;
      cyc(1);
      move_done = 1'b0;
   endtask
   task automatic count_door(output int n);
      n = 0;
      while (door_open && n < 100) begin
         n++;
         cyc(1);
      end
   endtask
   initial begin
      int n;
      cyc(2);
      chk("rst_outputs", {cmd_valid, cmd_dir, cmd_dist, current_floor, pending, door_open, busy}, 0);
      reset_p = 1'b0;
      cyc(1);
      // 1: single call to the top floor
      exp_q.push_back(3'b0_10);
      pulse_call(3'b100);
      chk("t1_latched", {pending, cmd_valid}, {3'b100, 1'b0});
      cyc(1);
      chk("t1_valid", {cmd_valid, cmd_dir, cmd_dist}, 4'b1_0_10);
      wait_accept();
      do_move(3);
      chk("t1_arrive", {door_open, current_floor}, {1'b1, 2'd2});
      count_door(n);
      chk("t1_dwell", n, 10);
      chk("t1_idle", {busy, pending}, 0);
      // 2: own-floor call opens the door, repeat pulse restarts the dwell
      do_reset();
      pulse_call(3'b001);
      chk("t2_open", {door_open, cmd_valid, pending}, {1'b1, 1'b0, 3'b000});
      count_door(n);
      chk("t2_dwell", n, 10);
      pulse_call(3'b001);
      n = 0;
      while (door_open && n < 100) begin
         call_pe = (n == 4) ? 3'b001 : 3'b000;
         n++;
         cyc(1);
      end
      call_pe = '0;
      chk("t2_restart", n, 15);
      chk("t2_idle", {busy, pending}, 0);
      // 3: call for a passed floor served on the return sweep
      do_reset();
      exp_q.push_back(3'b0_10);
      pulse_call(3'b100);
      wait_accept();
      exp_q.push_back(3'b1_01);
      pulse_call(3'b010);
      do_move(2);
      chk("t3_pending", pending, 3'b010);
      count_door(n);
      chk("t3_dwell", n, 10);
      wait_accept();
      do_move(2);
      chk("t3_floor", current_floor, 1);
      count_door(n);
      chk("t3_idle", {busy, pending}, 0);
      // 4: sweep continues upward before reversing
      do_reset();
      exp_q.push_back(3'b0_01);
      pulse_call(3'b010);
      wait_accept();
      do_move(1);
      exp_q.push_back(3'b0_01);
      exp_q.push_back(3'b1_10);
      pulse_call(3'b101);
      count_door(n);
      chk("t4_dwell", n, 9);
      wait_accept();
      do_move(2);
      chk("t4_floor2", {current_floor, pending}, {2'd2, 3'b001});
      count_door(n);
      wait_accept();
      do_move(2);
      chk("t4_floor0", current_floor, 0);
      count_door(n);
      chk("t4_idle", {busy, pending}, 0);
      // 5: payload holds while the drive is not ready
      do_reset();
      cmd_ready = 1'b0;
      exp_q.push_back(3'b0_10);
      exp_q.push_back(3'b1_01);
      pulse_call(3'b100);
      cyc(1);
      for (int i = 0; i < 20; i++) begin
         chk("t5_hold", {cmd_valid, cmd_dir, cmd_dist}, 4'b1_0_10);
         call_pe = (i == 5) ? 3'b010 : 3'b000;
         cyc(1);
      end
      call_pe = '0;
      cmd_ready = 1'b1;
      wait_accept();
      do_move(1);
      count_door(n);
      wait_accept();
      do_move(1);
      chk("t5_floor", current_floor, 1);
      count_door(n);
      // 6: asynchronous reset in the middle of a move
      do_reset();
      exp_q.push_back(3'b0_10);
      pulse_call(3'b100);
      wait_accept();
      pulse_call(3'b010);
      chk("t6_moving", {busy, pending}, {1'b1, 3'b110});
      #2 reset_p = 1'b1;
      #1 chk("t6_async", {cmd_valid, cmd_dir, cmd_dist, current_floor, pending, door_open, busy}, 0);
      cyc(1);
      reset_p = 1'b0;
      cyc(1);
      do_move(0);
      cyc(2);
      chk("t6_ignored", {busy, door_open, current_floor}, 0);
      chk("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
